reg_file_wr_arb: RTL and testbench

// - Shares the single write port of a 1-write/2-read register file between NumReq requesters.
// - Per-requester valid/ready handshake, round-robin grant, registered write stage driving the

---
 rtl/reg_file_wr_arb_pkg.sv | 14 +
 rtl/reg_file_wr_arb_rr_arbiter.sv | 74 +++++++
 rtl/reg_file_wr_arb.sv | 93 +++++++++
 tb/tb_reg_file_wr_arb.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_wr_arb_pkg.sv
// Shared types and default sizing for the register-file write arbiter.
// Optional build macro: REG_FILE_WR_ARB_FIXED_PRIO_EN (fixed-priority arbitration).
package reg_file_wr_arb_pkg;

  typedef enum logic {
    ST_ARB = 1'b0,
    ST_CLR = 1'b1
  } arb_state_t;

  localparam int unsigned DefNumReq    = 4;
  localparam int unsigned DefDataWidth = 512;
  localparam int unsigned DefNumRegs   = 4;

endpackage

// File: rtl/reg_file_wr_arb_rr_arbiter.sv
// Round-robin arbiter with one-hot grant and binary index; advance_i moves the pointer.
// REG_FILE_WR_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins, no pointer state.
module rr_arbiter #(
  parameter int unsigned NumReq      = 4,
  parameter int unsigned NumReqWidth = $clog2(NumReq)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0]      req_i,
  input  logic                   advance_i,
  output logic [NumReq-1:0]      gnt_o,
  output logic [NumReqWidth-1:0] idx_o
);

`ifdef REG_FILE_WR_ARB_FIXED_PRIO_EN

  logic unused_inputs;
  assign unused_inputs = ^{clk_i, rst_ni, advance_i};

  // Lowest-index requester wins.
  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      if (!found && req_i[i]) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = NumReqWidth'(i);
      end
    end
  end

`else

  // ptr_q is the first index searched: one past the last granted requester.
  logic [NumReqWidth-1:0] ptr_q;

  always_comb begin
    logic                   found;
    int unsigned            pos;
    logic [NumReqWidth-1:0] pos_idx;
    found   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    gnt_o   = '0;
    idx_o   = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      pos     = (32'(ptr_q) + i) % NumReq;
      pos_idx = NumReqWidth'(pos);
      if (!found && req_i[pos_idx]) begin
        found          = 1'b1;
        gnt_o[pos_idx] = 1'b1;
        idx_o          = pos_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (advance_i) begin
      if (32'(idx_o) == NumReq - 1) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= idx_o + NumReqWidth'(1);
      end
    end
  end

`endif

endmodule

// File: rtl/reg_file_wr_arb.sv
// Shares the register file's single write port between NumReq requesters; handles whole-file clear.
// Build macro REG_FILE_WR_ARB_FIXED_PRIO_EN selects fixed-priority arbitration in rr_arbiter.
module reg_file_wr_arb
  import reg_file_wr_arb_pkg::*;
#(
  parameter int unsigned NumReq       = DefNumReq,
  parameter int unsigned DataWidth    = DefDataWidth,
  parameter int unsigned NumRegs      = DefNumRegs,
  parameter int unsigned NumRegsWidth = $clog2(NumRegs),
  parameter int unsigned NumReqWidth  = $clog2(NumReq)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumReq-1:0]                      req_valid_i,
  output logic [NumReq-1:0]                      req_ready_o,
  input  logic [NumReq-1:0][NumRegsWidth-1:0]    req_addr_i,
  input  logic [NumReq-1:0][DataWidth-1:0]       req_data_i,
  input  logic                                   clr_req_i,
  output logic                                   clr_ack_o,
  output logic                                   rf_clr_o,
  output logic                                   rf_wr_en_o,
  output logic [NumRegsWidth-1:0]                rf_wr_addr_o,
  output logic [DataWidth-1:0]                   rf_wr_data_o,
  output logic [NumRegs-1:0]                     reg_valid_o,
  output logic                                   busy_o
);

  arb_state_t             state_q;
  logic [NumReq-1:0]      gnt;
  logic [NumReqWidth-1:0] gnt_idx;
  logic                   grant_open;
  logic                   grant_fire;

  // Grants only in ST_ARB with no clear pending; reset forces ready low immediately.
  assign grant_open  = rst_ni && (state_q == ST_ARB) && !clr_req_i;
  assign req_ready_o = grant_open ? gnt : '0;
  assign grant_fire  = |req_ready_o;

  rr_arbiter #(
    .NumReq      (NumReq),
    .NumReqWidth (NumReqWidth)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_valid_i),
    .advance_i (grant_fire),
    .gnt_o     (gnt),
    .idx_o     (gnt_idx)
  );

  // FSM, write stage and scoreboard; the clear in ST_CLR overrides any scoreboard set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_ARB;
      clr_ack_o    <= 1'b0;
      rf_clr_o     <= 1'b0;
      rf_wr_en_o   <= 1'b0;
      rf_wr_addr_o <= '0;
      rf_wr_data_o <= '0;
      reg_valid_o  <= '0;
      busy_o       <= 1'b0;
    end else begin
      clr_ack_o  <= 1'b0;
      rf_clr_o   <= 1'b0;
      rf_wr_en_o <= 1'b0;
      busy_o     <= 1'b0;
      if (rf_wr_en_o) begin
        reg_valid_o[rf_wr_addr_o] <= 1'b1;
      end
      unique case (state_q)
        ST_ARB: begin
          if (clr_req_i) begin
            state_q   <= ST_CLR;
            clr_ack_o <= 1'b1;
            rf_clr_o  <= 1'b1;
            busy_o    <= 1'b1;
          end else if (grant_fire) begin
            rf_wr_en_o   <= 1'b1;
            rf_wr_addr_o <= req_addr_i[gnt_idx];
            rf_wr_data_o <= req_data_i[gnt_idx];
            busy_o       <= 1'b1;
          end
        end
        ST_CLR: begin
          state_q     <= ST_ARB;
          reg_valid_o <= '0;
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_wr_arb.sv
// Directed self-checking bench for reg_file_wr_arb (4 requesters, 4 x 512-bit registers).
// Expectations follow REG_FILE_WR_ARB_FIXED_PRIO_EN when the build defines it.
module tb_reg_file_wr_arb;

  localparam int unsigned NumReq    = 4;
  localparam int unsigned DataWidth = 512;
  localparam int unsigned NumRegs   = 4;

  logic                        clk;
  logic                        rst_n;
  logic [NumReq-1:0]           req_valid;
  logic [NumReq-1:0]           req_ready;
  logic [NumReq-1:0][1:0]      req_addr;
  logic [NumReq-1:0][DataWidth-1:0] req_data;
  logic                        clr_req;
  logic                        clr_ack;
  logic                        rf_clr;
  logic                        rf_wr_en;
  logic [1:0]                  rf_wr_addr;
  logic [DataWidth-1:0]        rf_wr_data;
  logic [NumRegs-1:0]          reg_valid;
  logic                        busy;

  int unsigned n_checks;
  int unsigned n_fail;

  reg_file_wr_arb #(
    .NumReq    (NumReq),
    .DataWidth (DataWidth),
    .NumRegs   (NumRegs)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .clr_req_i    (clr_req),
    .clr_ack_o    (clr_ack),
    .rf_clr_o     (rf_clr),
    .rf_wr_en_o   (rf_wr_en),
    .rf_wr_addr_o (rf_wr_addr),
    .rf_wr_data_o (rf_wr_data),
    .reg_valid_o  (reg_valid),
    .busy_o       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DataWidth-1:0] obs,
                       input logic [DataWidth-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycle boundary: inputs are driven 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic logic [DataWidth-1:0] data_of(input int unsigned i);
    logic [DataWidth-1:0] d;
    logic [7:0]           b;
    b = 8'h11 * 8'(i + 1);
    for (int j = 0; j < DataWidth / 8; j++) d[j*8 +: 8] = b;
    return d;
  endfunction

  // Requester granted in cycle k of the all-valid contention run.
  function automatic int unsigned exp_idx(input int unsigned k);
`ifdef REG_FILE_WR_ARB_FIXED_PRIO_EN
    return 0 * k;
`else
    return k % NumReq;
`endif
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"},   DataWidth'(rf_wr_en),   '0);
    check({tag, "_addr"},    DataWidth'(rf_wr_addr), '0);
    check({tag, "_data"},    rf_wr_data,             '0);
    check({tag, "_rvalid"},  DataWidth'(reg_valid),  '0);
    check({tag, "_busy"},    DataWidth'(busy),       '0);
    check({tag, "_clr"},     DataWidth'(rf_clr),     '0);
    check({tag, "_ack"},     DataWidth'(clr_ack),    '0);
  endtask

  initial begin
    logic [NumReq-1:0]  all_written;
    logic [DataWidth-1:0] a5;
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    clr_req   = 1'b0;
    req_valid = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_addr[i] = 2'(i);
      req_data[i] = data_of(i);
    end
    repeat (3) tick();
    check_idle_outputs("reset");
    check("reset_ready", DataWidth'(req_ready), '0);
    rst_n = 1'b1;

    // Contention: all four valid for 8 cycles.
    tick();
    for (int unsigned k = 0; k < 8; k++) begin
      req_valid = 4'hF;
      settle();
      check($sformatf("cont_ready_%0d", k), DataWidth'(req_ready),
            DataWidth'(4'(1) << exp_idx(k)));
      if (k > 0) begin
        check($sformatf("cont_wren_%0d", k), DataWidth'(rf_wr_en), DataWidth'(1'b1));
        check($sformatf("cont_addr_%0d", k), DataWidth'(rf_wr_addr),
              DataWidth'(exp_idx(k - 1)));
        check($sformatf("cont_data_%0d", k), rf_wr_data, data_of(exp_idx(k - 1)));
      end
      tick();
    end
    req_valid = '0;
    settle();
    check("cont_last_ready", DataWidth'(req_ready), '0);
    check("cont_last_wren", DataWidth'(rf_wr_en), DataWidth'(1'b1));
    check("cont_last_addr", DataWidth'(rf_wr_addr), DataWidth'(exp_idx(7)));
    tick();
`ifdef REG_FILE_WR_ARB_FIXED_PRIO_EN
    all_written = 4'b0001;
`else
    all_written = 4'b1111;
`endif
    check("cont_rvalid", DataWidth'(reg_valid), DataWidth'(all_written));
    check("cont_idle_wren", DataWidth'(rf_wr_en), '0);
    check("cont_idle_busy", DataWidth'(busy), '0);
    check("cont_hold_addr", DataWidth'(rf_wr_addr), DataWidth'(exp_idx(7)));

    // Held clear for three cycles: two separate clear pulses.
    clr_req   = 1'b1;
    req_valid = 4'hF;
    settle();
    check("hclr_c0_ready", DataWidth'(req_ready), '0);
    tick();
    check("hclr_c1_ack", DataWidth'(clr_ack), DataWidth'(1'b1));
    check("hclr_c1_clr", DataWidth'(rf_clr), DataWidth'(1'b1));
    check("hclr_c1_busy", DataWidth'(busy), DataWidth'(1'b1));
    check("hclr_c1_ready", DataWidth'(req_ready), '0);
    tick();
    check("hclr_c2_ack", DataWidth'(clr_ack), '0);
    check("hclr_c2_ready", DataWidth'(req_ready), '0);
    check("hclr_c2_rvalid", DataWidth'(reg_valid), '0);
    tick();
    clr_req   = 1'b0;
    req_valid = '0;
    settle();
    check("hclr_c3_ack", DataWidth'(clr_ack), DataWidth'(1'b1));
    check("hclr_c3_clr", DataWidth'(rf_clr), DataWidth'(1'b1));
    tick();
    check("hclr_c4_ack", DataWidth'(clr_ack), '0);
    check("hclr_c4_busy", DataWidth'(busy), '0);

    // Single write from requester 2.
    a5 = {64{8'hA5}};
    req_data[2] = a5;
    req_valid   = 4'b0100;
    settle();
    check("single_ready", DataWidth'(req_ready), DataWidth'(4'b0100));
    tick();
    req_valid = '0;
    settle();
    check("single_wren", DataWidth'(rf_wr_en), DataWidth'(1'b1));
    check("single_addr", DataWidth'(rf_wr_addr), DataWidth'(2'd2));
    check("single_data", rf_wr_data, a5);
    check("single_busy", DataWidth'(busy), DataWidth'(1'b1));
    check("single_rvalid_t1", DataWidth'(reg_valid), '0);
    tick();
    check("single_rvalid_t2", DataWidth'(reg_valid), DataWidth'(4'b0100));
    check("single_wren_off", DataWidth'(rf_wr_en), '0);
    check("single_hold_data", rf_wr_data, a5);

    // Write in flight when clear arrives: clear lands after the write.
    req_valid = 4'b0010;
    settle();
    check("cvw_t_ready", DataWidth'(req_ready), DataWidth'(4'b0010));
    tick();
    req_valid = '0;
    clr_req   = 1'b1;
    settle();
    check("cvw_t1_ready", DataWidth'(req_ready), '0);
    check("cvw_t1_wren", DataWidth'(rf_wr_en), DataWidth'(1'b1));
    check("cvw_t1_addr", DataWidth'(rf_wr_addr), DataWidth'(2'd1));
    check("cvw_t1_clr", DataWidth'(rf_clr), '0);
    tick();
    clr_req   = 1'b0;
    req_valid = 4'b0010;
    settle();
    check("cvw_t2_ready", DataWidth'(req_ready), '0);
    check("cvw_t2_clr", DataWidth'(rf_clr), DataWidth'(1'b1));
    check("cvw_t2_ack", DataWidth'(clr_ack), DataWidth'(1'b1));
    check("cvw_t2_wren", DataWidth'(rf_wr_en), '0);
    check("cvw_t2_rvalid", DataWidth'(reg_valid), DataWidth'(4'b0110));
    req_valid = '0;
    tick();
    check("cvw_t3_rvalid", DataWidth'(reg_valid), '0);
    check("cvw_t3_ack", DataWidth'(clr_ack), '0);
    check("cvw_t3_busy", DataWidth'(busy), '0);

    // Asynchronous reset while a write is on the port.
    req_valid = 4'b1000;
    settle();
    check("rst_grant", DataWidth'(req_ready), DataWidth'(4'b1000));
    tick();
    req_valid = '0;
    settle();
    check("rst_pre_wren", DataWidth'(rf_wr_en), DataWidth'(1'b1));
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    tick();
    tick();
    rst_n     = 1'b1;
    req_valid = 4'hF;
    settle();
    check("rst_after_ready", DataWidth'(req_ready), DataWidth'(4'b0001));
    tick();
    req_valid = '0;
    settle();
    check("rst_after_addr", DataWidth'(rf_wr_addr), '0);
    check("rst_after_data", rf_wr_data, data_of(0));
    tick();
    check("rst_after_rvalid", DataWidth'(reg_valid), DataWidth'(4'b0001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
